// File: rtl/sine_width_gen.sv
// sine_width_gen: phase-accumulator waveform source emitting PWM width samples centred on WIDTH_MAX/2.
// Latency: 2 clk from prescaler tick to widthSine/sample_valid; one sample per TICK_MAX enabled cycles.
// Backpressure: none, every sample_valid pulse must be taken. Optional macro AMP_SCALE_EN adds amplitude input.
module sine_width_gen #(
   parameter int TICK_MAX   = 1000,
   parameter int PHASE_BITS = 16,
   parameter int LUT_BITS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH_MAX  = 1000,
   // Name of the hex image holding the quarter-wave table. The table is regenerated
   // at elaboration from the same formula, so the file itself is not read.
   parameter     INIT_FILE  = "sine_quarter.hex"
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [PHASE_BITS-1:0] freq_word,
   input  logic [1:0]            mode,
`ifdef AMP_SCALE_EN
   input  logic [7:0]            amplitude,
`endif
   output logic [DATA_WIDTH-1:0] widthSine,
   output logic                  sample_valid,
   output logic                  phase_wrap
);

   localparam int AW = DATA_WIDTH + 8;          // internal arithmetic width
   localparam int IW = LUT_BITS + 2;            // full-wave index width
   localparam int N  = 2 ** LUT_BITS;           // quarter-wave table depth
   localparam int CW = $clog2(TICK_MAX);
   localparam int MID = WIDTH_MAX / 2;
   localparam logic [AW-1:0] MID_A  = AW'(MID);
   localparam logic [AW-1:0] WMAX_A = AW'(WIDTH_MAX);

   // round(MID*sin((k+0.5)*pi/2^(LUT_BITS+1))) via a Q30 Taylor series, elaboration only
   function automatic logic [DATA_WIDTH-1:0] sine_entry(input int k);
      longint x, x2, term, sum, scaled;
      x    = (64'sd3373259426 * longint'(2 * k + 1)) >>> (LUT_BITS + 2);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 7; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      scaled = (sum * longint'(MID) + (64'sd1 <<< 29)) >>> 30;
      return DATA_WIDTH'(scaled);
   endfunction

   typedef struct packed {
      logic            vld;
      logic            neg;    // lower half of the wave (quadrants 2,3)
      logic [1:0]      mode;
      logic [IW-1:0]   idx;
      logic [AW-1:0]   mag;
`ifdef AMP_SCALE_EN
      logic [7:0]      amp;
`endif
   } stage_t;

   logic [DATA_WIDTH-1:0] lut [N];
   logic [CW-1:0]         count;
   logic                  tick;
   logic [PHASE_BITS-1:0] phase;
   logic [PHASE_BITS:0]   phase_sum;
   logic [IW-1:0]         idx0;
   logic [1:0]            q0;
   logic [LUT_BITS-1:0]   i0, im0;
   logic [AW-1:0]         mag0, mag2, res;
   stage_t                s1;

   for (genvar k = 0; k < N; k++) begin : g_lut
      localparam logic [DATA_WIDTH-1:0] ENTRY = sine_entry(k);
      assign lut[k] = ENTRY;
   end

   assign tick      = enable && (count == CW'(TICK_MAX - 1));
   assign phase_sum = {1'b0, phase} + {1'b0, freq_word};
   assign idx0      = phase[PHASE_BITS-1 -: IW];
   assign q0        = idx0[IW-1 -: 2];
   assign i0        = idx0[LUT_BITS-1:0];
   assign im0       = q0[0] ? ~i0 : i0;   // odd quadrants run the table backwards

   // Prescaler: free-runs while enabled, holds its count otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (enable)
         count <= tick ? '0 : count + CW'(1);
   end

   // Phase accumulator; carry-out reported the cycle after the tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase      <= '0;
         phase_wrap <= 1'b0;
      end else begin
         phase_wrap <= tick & phase_sum[PHASE_BITS];
         if (tick)
            phase <= phase_sum[PHASE_BITS-1:0];
      end
   end

   // Magnitude for the current phase: table lookup or linear ramp
   always_comb begin
      mag0 = '0;
      case (mode)
         2'd0:    mag0 = AW'(lut[im0]);
         2'd1:    mag0 = (AW'({im0, 1'b1}) * MID_A) >> (LUT_BITS + 1);
         default: mag0 = '0;
      endcase
   end

   // First pipeline register: captured on tick using the pre-increment phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
      end else begin
         s1.vld <= tick;
         if (tick) begin
            s1.neg  <= q0[1];
            s1.mode <= mode;
            s1.idx  <= idx0;
            s1.mag  <= mag0;
`ifdef AMP_SCALE_EN
            s1.amp  <= amplitude;
`endif
         end
      end
   end

   // Final sample value from the registered magnitude and mode
   always_comb begin
`ifdef AMP_SCALE_EN
      mag2 = (s1.mag * AW'({1'b0, s1.amp} + 9'd1)) >> 8;
`else
      mag2 = s1.mag;
`endif
      res = MID_A;
      case (s1.mode)
         2'd0, 2'd1: res = s1.neg ? (MID_A - mag2) : (MID_A + mag2);
         2'd2:       res = (AW'(s1.idx) * WMAX_A) >> IW;
         default:    res = MID_A;
      endcase
   end

   // Output register with one-cycle valid strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widthSine    <= DATA_WIDTH'(MID);
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= s1.vld;
         if (s1.vld)
            widthSine <= res[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_sine_width_gen.sv
// tb_sine_width_gen: directed tests for sine_width_gen with TICK_MAX=4, PHASE_BITS=8, LUT_BITS=4.
// Expected values are hand-derived from the waveform formulas.
// Define AMP_SCALE_EN to also exercise the amplitude input.
module tb_sine_width_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  freq_word = 8'd4;
   logic [1:0]  mode = 2'd0;
   logic [31:0] widthSine;
   logic        sample_valid;
   logic        phase_wrap;
`ifdef AMP_SCALE_EN
   logic [7:0]  amplitude = 8'd255;
`endif

   int checks = 0;
   int fails  = 0;
   int wrap_cnt = 0;

   sine_width_gen #(
      .TICK_MAX(4), .PHASE_BITS(8), .LUT_BITS(4), .DATA_WIDTH(32), .WIDTH_MAX(1000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .freq_word(freq_word),
      .mode(mode),
`ifdef AMP_SCALE_EN
      .amplitude(amplitude),
`endif
      .widthSine(widthSine),
      .sample_valid(sample_valid),
      .phase_wrap(phase_wrap)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (phase_wrap) wrap_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until the next sample_valid pulse (bounded); returns value and cycles taken
   task automatic next_sample(output int w, output int n);
      n = 1;
      step();
      while (!sample_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (!sample_valid) begin
         fails++;
         $display("FAIL sample_timeout: no sample_valid within %0d cycles", n);
      end
      w = int'(widthSine);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int e;
      rst = 1'b1; enable = 1'b0; freq_word = 8'd4; mode = 2'd0;
      step(); step();
      checks++; if (widthSine !== 32'd500) begin fails++; $display("FAIL reset_width: got %0d expected 500", widthSine); end
      checks++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
      checks++; if (phase_wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b expected 0", phase_wrap); end
      rst = 1'b0; enable = 1'b1;
      for (e = 1; e <= 5; e++) begin
         step();
         checks++;
         if (sample_valid !== (e == 5)) begin
            fails++; $display("FAIL first_latency cycle %0d: valid %b expected %b", e, sample_valid, (e == 5));
         end
      end
      checks++; if (widthSine !== 32'd525) begin fails++; $display("FAIL first_sample: got %0d expected 525", widthSine); end
      // next tick is in flight after three more edges; reset must flush it
      step(); step(); step();
      rst = 1'b1;
      #1;
      checks++; if (widthSine !== 32'd500) begin fails++; $display("FAIL midreset_width: got %0d expected 500", widthSine); end
      step();
      rst = 1'b0;
      for (e = 1; e <= 4; e++) begin
         step();
         checks++;
         if (sample_valid !== 1'b0) begin fails++; $display("FAIL flushed_sample cycle %0d: valid %b expected 0", e, sample_valid); end
      end
   endtask

   task automatic test_sine_sweep();
      int s [64];
      int n, w0, per;
      mode = 2'd0; freq_word = 8'd4; enable = 1'b1;
      reset_dut();
      w0 = wrap_cnt;
      per = 0;
      for (int k = 0; k < 64; k++) begin
         next_sample(s[k], n);
         if (k == 2) per = n;
      end
      checks++; if (s[0]  !== 525) begin fails++; $display("FAIL sine_s0: got %0d expected 525", s[0]); end
      checks++; if (s[15] !== 999) begin fails++; $display("FAIL sine_s15: got %0d expected 999", s[15]); end
      checks++; if (s[16] !== 999) begin fails++; $display("FAIL sine_s16: got %0d expected 999", s[16]); end
      checks++; if (s[31] !== 525) begin fails++; $display("FAIL sine_s31: got %0d expected 525", s[31]); end
      checks++; if (s[32] !== 475) begin fails++; $display("FAIL sine_s32: got %0d expected 475", s[32]); end
      checks++; if (s[48] !== 1)   begin fails++; $display("FAIL sine_s48: got %0d expected 1", s[48]); end
      checks++; if (wrap_cnt - w0 !== 1) begin fails++; $display("FAIL sine_wraps: got %0d expected 1", wrap_cnt - w0); end
      checks++; if (per !== 4) begin fails++; $display("FAIL sample_period: got %0d expected 4", per); end
   endtask

   task automatic test_modes();
      int s [64];
      int n;
      mode = 2'd1;
      reset_dut();
      for (int k = 0; k < 33; k++) next_sample(s[k], n);
      checks++; if (s[0]  !== 515) begin fails++; $display("FAIL tri_s0: got %0d expected 515", s[0]); end
      checks++; if (s[15] !== 984) begin fails++; $display("FAIL tri_s15: got %0d expected 984", s[15]); end
      checks++; if (s[32] !== 485) begin fails++; $display("FAIL tri_s32: got %0d expected 485", s[32]); end
      mode = 2'd2;
      reset_dut();
      for (int k = 0; k < 64; k++) next_sample(s[k], n);
      checks++; if (s[0]  !== 0)   begin fails++; $display("FAIL saw_s0: got %0d expected 0", s[0]); end
      checks++; if (s[5]  !== 78)  begin fails++; $display("FAIL saw_s5: got %0d expected 78", s[5]); end
      checks++; if (s[32] !== 500) begin fails++; $display("FAIL saw_s32: got %0d expected 500", s[32]); end
      checks++; if (s[63] !== 984) begin fails++; $display("FAIL saw_s63: got %0d expected 984", s[63]); end
      mode = 2'd3;
      reset_dut();
      for (int k = 0; k < 5; k++) begin
         next_sample(s[k], n);
         checks++; if (s[k] !== 500) begin fails++; $display("FAIL hold_s%0d: got %0d expected 500", k, s[k]); end
      end
      mode = 2'd0;
   endtask

   task automatic test_enable();
      int w, n;
      mode = 2'd0; freq_word = 8'd4; enable = 1'b1;
      reset_dut();
      next_sample(w, n);
      step();
      enable = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL disabled_valid cycle %0d: got %b expected 0", c, sample_valid); end
      end
      enable = 1'b1;
      next_sample(w, n);
      checks++; if (n !== 3) begin fails++; $display("FAIL resume_latency: got %0d expected 3", n); end
      checks++; if (w !== 573) begin fails++; $display("FAIL resume_sample: got %0d expected 573", w); end
      // drop enable right after the tick edge: the in-flight sample must still emerge
      step(); step(); step();
      enable = 1'b0;
      step();
      checks++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL inflight_valid: got %b expected 1", sample_valid); end
      checks++; if (widthSine !== 32'd621) begin fails++; $display("FAIL inflight_sample: got %0d expected 621", widthSine); end
      enable = 1'b1;
   endtask

   task automatic test_freq_edges();
      int w, n, w0;
      freq_word = 8'd0; mode = 2'd0;
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         next_sample(w, n);
         checks++; if (w !== 525) begin fails++; $display("FAIL freeze_s%0d: got %0d expected 525", k, w); end
      end
      freq_word = 8'd255;
      reset_dut();
      w0 = wrap_cnt;
      next_sample(w, n);
      checks++; if (w !== 525) begin fails++; $display("FAIL dec_s0: got %0d expected 525", w); end
      checks++; if (wrap_cnt - w0 !== 0) begin fails++; $display("FAIL dec_wrap0: got %0d expected 0", wrap_cnt - w0); end
      next_sample(w, n);
      checks++; if (w !== 475) begin fails++; $display("FAIL dec_s1: got %0d expected 475", w); end
      checks++; if (wrap_cnt - w0 !== 1) begin fails++; $display("FAIL dec_wrap1: got %0d expected 1", wrap_cnt - w0); end
      next_sample(w, n);
      checks++; if (w !== 475) begin fails++; $display("FAIL dec_s2: got %0d expected 475", w); end
      checks++; if (wrap_cnt - w0 !== 2) begin fails++; $display("FAIL dec_wrap2: got %0d expected 2", wrap_cnt - w0); end
      freq_word = 8'd4;
   endtask

`ifdef AMP_SCALE_EN
   task automatic test_amplitude();
      int s [64];
      int n;
      int amps [3] = '{127, 255, 0};
      int exps [3] = '{749, 999, 501};
      mode = 2'd0; freq_word = 8'd4;
      for (int a = 0; a < 3; a++) begin
         amplitude = 8'(amps[a]);
         reset_dut();
         for (int k = 0; k < 16; k++) next_sample(s[k], n);
         checks++; if (s[15] !== exps[a]) begin fails++; $display("FAIL amp%0d_s15: got %0d expected %0d", amps[a], s[15], exps[a]); end
      end
      mode = 2'd2; amplitude = 8'd0;
      reset_dut();
      for (int k = 0; k < 64; k++) next_sample(s[k], n);
      checks++; if (s[63] !== 984) begin fails++; $display("FAIL amp_saw_s63: got %0d expected 984", s[63]); end
      mode = 2'd0; amplitude = 8'd255;
   endtask
`endif

   initial begin
      test_reset();
      test_sine_sweep();
      test_modes();
      test_enable();
      test_freq_edges();
`ifdef AMP_SCALE_EN
      test_amplitude();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
